switch_mem_cfg: RTL and testbench
=================================

SWITCH_MEM_CFG -- requirements
Module: switch_mem_cfg

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The block SHALL have parameter WR_CNT_W, default 16, giving the width of the accepted-write counter.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 mem_sel_en  input  1  request strobe; one request per cycle while high.
REQ-006 mem_addr  input  8  register address.
REQ-007 mem_wr_data  input  8  write data.
REQ-008 mem_wr_rd_s  input  1  operation select: 1 = write, 0 = read.
REQ-009 mem_rd_data  output  32  read data, registered.
REQ-010 mem_ack  output  4  per-port write acknowledge pulse.
REQ-011 cfg_port_addr  output  32  port n address on bits [8n+7:8n], to the switch core.
REQ-012 cfg_port_valid  output  4  port n has been configured since reset.
REQ-013 cfg_lock  output  1  configuration lock, to the switch core.

Function
REQ-014 Register map SHALL be:
- 0x00-0x03 PORT_ADDR0-3: RW, 8 bits.
- 0x04 CTRL: RW, bit0 = lock; bit1 = clear_err, write-1 self-clearing, reads 0.
- 0x05 STATUS: RO, [3:0] = cfg_port_valid; [4] = dup_err; [5] = lock_err; [6] = addr_err; remaining bits 0.
- 0x06 WR_COUNT: RO, zero-extended to 32 bits.
REQ-015 A request SHALL be sampled on a rising clk edge with mem_sel_en = 1; while mem_sel_en = 0 all inputs SHALL be ignored.
REQ-016 Requests SHALL be fully pipelined; back-to-back requests on consecutive cycles SHALL all be processed in order.
REQ-017 A port write SHALL be accepted only if all of the following hold:
- address is 0x00-0x03;
- lock = 0;
- mem_wr_data differs from the address of every other port whose valid bit is 1.
REQ-018 On an accepted port write to port n, the block SHALL:
- update PORT_ADDRn and set cfg_port_valid[n] at the sampling edge;
- drive mem_ack = one-hot bit n for exactly the following cycle;
- increment WR_COUNT.
REQ-019 Rewriting port n with its own current value SHALL be accepted; it is not a duplicate.
REQ-020 A port write while lock = 1 SHALL leave state unchanged, produce no ack, and set lock_err.
REQ-021 A port write matching another valid port's address SHALL leave state unchanged, produce no ack, and set dup_err.
REQ-022 A write to CTRL SHALL always be accepted, including while locked, SHALL produce no ack, and SHALL increment WR_COUNT.
REQ-023 A CTRL write with clear_err = 1 SHALL clear dup_err, lock_err and addr_err, and SHALL take priority over any error set in the same cycle.
REQ-024 A write to 0x05, 0x06 or any unmapped address SHALL change no register and SHALL set addr_err.
REQ-025 A read SHALL update mem_rd_data on the cycle after sampling with the zero-extended register value; unmapped addresses SHALL return 0x00000000 and set addr_err.
REQ-026 mem_rd_data SHALL hold its last value until the next read.
REQ-027 Reads SHALL never assert mem_ack.
REQ-028 A read in the cycle after a write SHALL return the post-write value.
REQ-029 WR_COUNT SHALL saturate at 2^WR_CNT_W-1.
REQ-030 Error flags SHALL be sticky until cleared by clear_err.
REQ-031 cfg_port_addr, cfg_port_valid and cfg_lock SHALL be direct register outputs with no combinational path from the inputs.

Reset
REQ-032 While rst_n = 0, the block SHALL force all of the following:
- all PORT_ADDR registers = 0x00;
- cfg_port_valid = 0;
- lock = 0;
- all error flags = 0;
- WR_COUNT = 0;
- mem_rd_data = 0;
- mem_ack = 0.
REQ-033 Assertion of rst_n mid-operation SHALL abort any pending ack or read response immediately.
REQ-034 The first request SHALL be sampled on the first rising edge with rst_n = 1.

Verification
REQ-035 Write 0x11, 0x22, 0x33, 0x44 to 0x00-0x03 on consecutive cycles -> the following SHALL result:
- mem_ack = 0001, 0010, 0100, 1000 on the next four cycles;
- cfg_port_addr = 0x44332211;
- cfg_port_valid = 1111;
- WR_COUNT = 4.
REQ-036 With port0 = 0x11, write 0x11 to 0x01 -> the following SHALL result:
- no ack;
- PORT_ADDR1 unchanged;
- STATUS[4] = 1.
Then rewrite 0x11 to 0x00 -> mem_ack = 0001.
REQ-037 Write CTRL = 0x01, then write 0x55 to 0x02 -> the following SHALL result:
- no ack;
- STATUS[5] = 1;
- cfg_lock = 1.
Then write CTRL = 0x02 -> lock = 0 and STATUS[6:4] = 0.
REQ-038 Read 0x05 after the REQ-035 sequence -> mem_rd_data = 0x0000000F on the next cycle.
REQ-039 Read 0x80 -> mem_rd_data = 0x00000000 and STATUS[6] = 1.
REQ-040 Assert rst_n = 0 in the same cycle as a write ack -> mem_ack = 0 immediately, and all registers return to their reset values.

Source files
------------

// File: rtl/switch_mem_cfg.sv
// rtl/switch_mem_cfg.sv - register block holding per-port addresses, lock and error status for the switch core
module switch_mem_cfg #(
    parameter int WR_CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_sel_en,
    input  logic [7:0]  mem_addr,
    input  logic [7:0]  mem_wr_data,
    input  logic        mem_wr_rd_s,
    output logic [31:0] mem_rd_data,
    output logic [3:0]  mem_ack,
    output logic [31:0] cfg_port_addr,
    output logic [3:0]  cfg_port_valid,
    output logic        cfg_lock
);

    localparam logic [7:0] ADDR_CTRL   = 8'h04;
    localparam logic [7:0] ADDR_STATUS = 8'h05;
    localparam logic [7:0] ADDR_COUNT  = 8'h06;
    localparam logic [WR_CNT_W-1:0] WR_CNT_MAX = '1;

    logic [31:0]         port_addr_q, port_addr_d;
    logic [3:0]          valid_q, valid_d;
    logic                lock_q, lock_d;
    logic                dup_err_q, dup_err_d;
    logic                lock_err_q, lock_err_d;
    logic                addr_err_q, addr_err_d;
    logic [WR_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [31:0]         rd_data_q, rd_data_d;
    logic [3:0]          ack_q, ack_d;

    logic        wr_req;
    logic        rd_req;
    logic        is_port;
    logic        is_mapped;
    logic [1:0]  port_idx;
    logic        dup_hit;
    logic        cnt_inc;
    logic [31:0] rd_value;

    assign wr_req    = mem_sel_en & mem_wr_rd_s;
    assign rd_req    = mem_sel_en & ~mem_wr_rd_s;
    assign is_port   = (mem_addr[7:2] == 6'd0);
    assign is_mapped = (mem_addr <= ADDR_COUNT);
    assign port_idx  = mem_addr[1:0];

    // A port may keep its own value; only other configured ports count as duplicates.
    always_comb begin
        dup_hit = 1'b0;
        for (int m = 0; m < 4; m++) begin
            if ((2'(m) != port_idx) && valid_q[m] && (port_addr_q[8*m +: 8] == mem_wr_data)) begin
                dup_hit = 1'b1;
            end
        end
    end

    always_comb begin
        rd_value = '0;
        if (is_port) begin
            rd_value[7:0] = port_addr_q[{port_idx, 3'b000} +: 8];
        end else if (mem_addr == ADDR_CTRL) begin
            rd_value[0] = lock_q;
        end else if (mem_addr == ADDR_STATUS) begin
            rd_value[6:0] = {addr_err_q, lock_err_q, dup_err_q, valid_q};
        end else if (mem_addr == ADDR_COUNT) begin
            rd_value[WR_CNT_W-1:0] = wr_cnt_q;
        end
    end

    always_comb begin
        port_addr_d = port_addr_q;
        valid_d     = valid_q;
        lock_d      = lock_q;
        dup_err_d   = dup_err_q;
        lock_err_d  = lock_err_q;
        addr_err_d  = addr_err_q;
        wr_cnt_d    = wr_cnt_q;
        rd_data_d   = rd_data_q;
        ack_d       = '0;
        cnt_inc     = 1'b0;

        if (wr_req) begin
            if (is_port) begin
                if (lock_q) begin
                    lock_err_d = 1'b1;
                end else if (dup_hit) begin
                    dup_err_d = 1'b1;
                end else begin
                    port_addr_d[{port_idx, 3'b000} +: 8] = mem_wr_data;
                    valid_d[port_idx] = 1'b1;
                    ack_d[port_idx]   = 1'b1;
                    cnt_inc           = 1'b1;
                end
            end else if (mem_addr == ADDR_CTRL) begin
                lock_d  = mem_wr_data[0];
                cnt_inc = 1'b1;
            end else begin
                addr_err_d = 1'b1;
            end
        end

        if (rd_req) begin
            rd_data_d = rd_value;
            if (!is_mapped) begin
                addr_err_d = 1'b1;
            end
        end

        if (cnt_inc && (wr_cnt_q != WR_CNT_MAX)) begin
            wr_cnt_d = wr_cnt_q + WR_CNT_W'(1);
        end

        // clear_err wins over any flag raised by the same request.
        if (wr_req && (mem_addr == ADDR_CTRL) && mem_wr_data[1]) begin
            dup_err_d  = 1'b0;
            lock_err_d = 1'b0;
            addr_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_addr_q <= '0;
            valid_q     <= '0;
            lock_q      <= 1'b0;
            dup_err_q   <= 1'b0;
            lock_err_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            wr_cnt_q    <= '0;
            rd_data_q   <= '0;
            ack_q       <= '0;
        end else begin
            port_addr_q <= port_addr_d;
            valid_q     <= valid_d;
            lock_q      <= lock_d;
            dup_err_q   <= dup_err_d;
            lock_err_q  <= lock_err_d;
            addr_err_q  <= addr_err_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_data_q   <= rd_data_d;
            ack_q       <= ack_d;
        end
    end

    assign mem_rd_data    = rd_data_q;
    assign mem_ack        = ack_q;
    assign cfg_port_addr  = port_addr_q;
    assign cfg_port_valid = valid_q;
    assign cfg_lock       = lock_q;

endmodule

// File: tb/tb_switch_mem_cfg.sv
// tb/tb_switch_mem_cfg.sv - vector table, corner sequences and randomized model comparison for switch_mem_cfg
module tb_switch_mem_cfg;

    localparam int W = 4;

    logic        clk;
    logic        rst_n;
    logic        mem_sel_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wr_data;
    logic        mem_wr_rd_s;
    logic [31:0] mem_rd_data;
    logic [3:0]  mem_ack;
    logic [31:0] cfg_port_addr;
    logic [3:0]  cfg_port_valid;
    logic        cfg_lock;

    switch_mem_cfg #(.WR_CNT_W(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_sel_en     (mem_sel_en),
        .mem_addr       (mem_addr),
        .mem_wr_data    (mem_wr_data),
        .mem_wr_rd_s    (mem_wr_rd_s),
        .mem_rd_data    (mem_rd_data),
        .mem_ack        (mem_ack),
        .cfg_port_addr  (cfg_port_addr),
        .cfg_port_valid (cfg_port_valid),
        .cfg_lock       (cfg_lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic        wr;
        logic [3:0]  ack;
        logic [31:0] rd;
        logic [31:0] cfg;
        logic [3:0]  vld;
        logic        lock;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int          m_port[4];
    int          m_valid[4];
    int          m_lock, m_dup, m_lerr, m_aerr, m_cnt;
    logic [31:0] m_rd;
    logic [3:0]  m_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic sel, input logic [7:0] a, input logic [7:0] d, input logic wr,
                       input logic [3:0] ack, input logic [31:0] rd, input logic [31:0] cfg,
                       input logic [3:0] v, input logic lk);
        vec_t t;
        t.sel = sel; t.addr = a; t.data = d; t.wr = wr;
        t.ack = ack; t.rd = rd; t.cfg = cfg; t.vld = v; t.lock = lk;
        tbl.push_back(t);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_port[i] = 0;
            m_valid[i] = 0;
        end
        m_lock = 0; m_dup = 0; m_lerr = 0; m_aerr = 0; m_cnt = 0;
        m_rd = '0; m_ack = '0;
    endtask

    task automatic model_step(input logic sel, input int a, input int d, input logic wr);
        int dup;
        int vsum;
        m_ack = '0;
        if (!sel) return;
        if (wr) begin
            if (a < 4) begin
                if (m_lock != 0) begin
                    m_lerr = 1;
                end else begin
                    dup = 0;
                    for (int i = 0; i < 4; i++)
                        if (i != a && m_valid[i] != 0 && m_port[i] == d) dup = 1;
                    if (dup != 0) begin
                        m_dup = 1;
                    end else begin
                        m_port[a] = d;
                        m_valid[a] = 1;
                        m_ack = 4'(1 << a);
                        if (m_cnt < (1 << W) - 1) m_cnt++;
                    end
                end
            end else if (a == 4) begin
                m_lock = d % 2;
                if (m_cnt < (1 << W) - 1) m_cnt++;
                if ((d / 2) % 2 == 1) begin
                    m_dup = 0; m_lerr = 0; m_aerr = 0;
                end
            end else begin
                m_aerr = 1;
            end
        end else begin
            if (a < 4) m_rd = 32'(m_port[a]);
            else if (a == 4) m_rd = 32'(m_lock);
            else if (a == 5) begin
                vsum = 0;
                for (int i = 0; i < 4; i++) vsum += m_valid[i] * (1 << i);
                m_rd = 32'(vsum + 16 * m_dup + 32 * m_lerr + 64 * m_aerr);
            end else if (a == 6) m_rd = 32'(m_cnt);
            else begin
                m_rd = '0;
                m_aerr = 1;
            end
        end
    endtask

    task automatic step(input logic sel, input logic [7:0] a, input logic [7:0] d, input logic wr);
        mem_sel_en = sel; mem_addr = a; mem_wr_data = d; mem_wr_rd_s = wr;
        @(posedge clk);
        model_step(sel, int'(a), int'(d), wr);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, " ack"},   32'(mem_ack), 32'(m_ack));
        check({tag, " rd"},    mem_rd_data, m_rd);
        check({tag, " cfg"},   cfg_port_addr,
              {8'(m_port[3]), 8'(m_port[2]), 8'(m_port[1]), 8'(m_port[0])});
        check({tag, " valid"}, 32'(cfg_port_valid),
              32'(m_valid[0] + 2 * m_valid[1] + 4 * m_valid[2] + 8 * m_valid[3]));
        check({tag, " lock"},  32'(cfg_lock), 32'(m_lock));
    endtask

    initial begin
        logic [7:0] ra, rd8;
        logic       rs, rw;
        int         r;

        rst_n = 1'b0; mem_sel_en = 1'b0; mem_addr = '0; mem_wr_data = '0; mem_wr_rd_s = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset ack", 32'(mem_ack), 32'h0);
        check("reset rd", mem_rd_data, 32'h0);
        check("reset cfg", cfg_port_addr, 32'h0);
        check("reset valid", 32'(cfg_port_valid), 32'h0);
        check("reset lock", 32'(cfg_lock), 32'h0);
        rst_n = 1'b1;

        //   sel addr   data   wr  ack      rd             cfg            vld      lock
        add(1, 8'h00, 8'h11, 1, 4'b0001, 32'h0,        32'h00000011, 4'b0001, 0);
        add(1, 8'h01, 8'h22, 1, 4'b0010, 32'h0,        32'h00002211, 4'b0011, 0);
        add(1, 8'h02, 8'h33, 1, 4'b0100, 32'h0,        32'h00332211, 4'b0111, 0);
        add(1, 8'h03, 8'h44, 1, 4'b1000, 32'h0,        32'h44332211, 4'b1111, 0);
        add(1, 8'h05, 8'h00, 0, 4'b0000, 32'h0000000F, 32'h44332211, 4'b1111, 0);
        add(1, 8'h06, 8'h00, 0, 4'b0000, 32'h00000004, 32'h44332211, 4'b1111, 0);
        add(1, 8'h01, 8'h11, 1, 4'b0000, 32'h00000004, 32'h44332211, 4'b1111, 0);
        add(1, 8'h05, 8'h00, 0, 4'b0000, 32'h0000001F, 32'h44332211, 4'b1111, 0);
        add(1, 8'h00, 8'h11, 1, 4'b0001, 32'h0000001F, 32'h44332211, 4'b1111, 0);
        add(1, 8'h04, 8'h01, 1, 4'b0000, 32'h0000001F, 32'h44332211, 4'b1111, 1);
        add(1, 8'h02, 8'h55, 1, 4'b0000, 32'h0000001F, 32'h44332211, 4'b1111, 1);
        add(1, 8'h05, 8'h00, 0, 4'b0000, 32'h0000003F, 32'h44332211, 4'b1111, 1);
        add(1, 8'h04, 8'h02, 1, 4'b0000, 32'h0000003F, 32'h44332211, 4'b1111, 0);
        add(1, 8'h05, 8'h00, 0, 4'b0000, 32'h0000000F, 32'h44332211, 4'b1111, 0);
        add(1, 8'h80, 8'h00, 0, 4'b0000, 32'h00000000, 32'h44332211, 4'b1111, 0);
        add(1, 8'h05, 8'h00, 0, 4'b0000, 32'h0000004F, 32'h44332211, 4'b1111, 0);
        add(1, 8'h06, 8'h99, 1, 4'b0000, 32'h0000004F, 32'h44332211, 4'b1111, 0);
        add(0, 8'h00, 8'h77, 1, 4'b0000, 32'h0000004F, 32'h44332211, 4'b1111, 0);
        add(1, 8'h04, 8'h00, 0, 4'b0000, 32'h00000000, 32'h44332211, 4'b1111, 0);
        add(1, 8'h06, 8'h00, 0, 4'b0000, 32'h00000007, 32'h44332211, 4'b1111, 0);
        add(1, 8'h01, 8'h00, 0, 4'b0000, 32'h00000022, 32'h44332211, 4'b1111, 0);
        add(1, 8'h02, 8'h66, 1, 4'b0100, 32'h00000022, 32'h44662211, 4'b1111, 0);
        add(1, 8'h02, 8'h00, 0, 4'b0000, 32'h00000066, 32'h44662211, 4'b1111, 0);

        @(negedge clk);
        foreach (tbl[i]) begin
            step(tbl[i].sel, tbl[i].addr, tbl[i].data, tbl[i].wr);
            check($sformatf("v%0d ack", i),   32'(mem_ack), 32'(tbl[i].ack));
            check($sformatf("v%0d rd", i),    mem_rd_data, tbl[i].rd);
            check($sformatf("v%0d cfg", i),   cfg_port_addr, tbl[i].cfg);
            check($sformatf("v%0d valid", i), 32'(cfg_port_valid), 32'(tbl[i].vld));
            check($sformatf("v%0d lock", i),  32'(cfg_lock), 32'(tbl[i].lock));
        end

        // Count reaches 2^W-1 and must stay there.
        for (int k = 0; k < 10; k++) begin
            step(1, 8'h04, 8'h00, 1);
            check("sat ctrl ack", 32'(mem_ack), 32'h0);
        end
        step(1, 8'h06, 8'h00, 0);
        check("sat count", mem_rd_data, 32'h0000000F);

        // Reset asserted while a write ack is on the output.
        mem_sel_en = 1'b1; mem_addr = 8'h03; mem_wr_data = 8'h77; mem_wr_rd_s = 1'b1;
        @(posedge clk);
        #1;
        check("pre-reset ack", 32'(mem_ack), 32'h8);
        mem_sel_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("mid-reset ack", 32'(mem_ack), 32'h0);
        check("mid-reset rd", mem_rd_data, 32'h0);
        check("mid-reset cfg", cfg_port_addr, 32'h0);
        check("mid-reset valid", 32'(cfg_port_valid), 32'h0);
        check("mid-reset lock", 32'(cfg_lock), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1, 8'h05, 8'h00, 0);
        check("post-reset status", mem_rd_data, 32'h0);
        step(1, 8'h06, 8'h00, 0);
        check("post-reset count", mem_rd_data, 32'h0);

        for (int k = 0; k < 2000; k++) begin
            rs = ($urandom_range(0, 9) != 0);
            rw = $urandom_range(0, 1) == 1;
            r  = $urandom_range(0, 15);
            if (r < 8) ra = 8'(r);
            else if (r < 14) ra = 8'(r % 4);
            else ra = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rd8 = 8'($urandom);
            else rd8 = 8'(8'h10 + $urandom_range(0, 5));
            step(rs, ra, rd8, rw);
            check_model($sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
